// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: handshake and RAM/twiddle address bundle between the NTT sequencer and its environment.
//   start_i, mode_i        : start request and transform select (1 = forward CT, 0 = inverse GS)
//   busy_o, done_o, ct_o   : operation status and butterfly CT/GS select
//   rd_en_o, rd_addr_*_o   : coefficient read strobe and even/odd read addresses
//   tw_idx_o               : twiddle ROM index aligned with rd_en_o
//   wr_en_o, wr_addr_*_o   : in-place write strobe and even/odd write addresses
//   master drives start_i/mode_i, slave (the sequencer) drives everything else.
interface ntt_ctrl_if;
    logic       start_i;
    logic       mode_i;
    logic       busy_o;
    logic       done_o;
    logic       ct_o;
    logic       rd_en_o;
    logic [7:0] rd_addr_a_o;
    logic [7:0] rd_addr_b_o;
    logic [7:0] tw_idx_o;
    logic       wr_en_o;
    logic [7:0] wr_addr_a_o;
    logic [7:0] wr_addr_b_o;
    modport master (
        output start_i, mode_i,
        input  busy_o, done_o, ct_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
               wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
    modport slave (
        input  start_i, mode_i,
        output busy_o, done_o, ct_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
               wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequences a 256-point Dilithium NTT (forward CT) or inverse NTT (GS) over the butterfly unit.
//   clk_i : clock
//   rst_i : synchronous active-high reset, aborts any operation
//   bus   : ntt_ctrl_if.slave -- start/mode in; busy, done, CT select, read addresses,
//           twiddle index and PIPE_LAT-delayed in-place write addresses out.
module ntt_ctrl #(
    parameter int PIPE_LAT = 1
) (
    input logic       clk_i,
    input logic       rst_i,
    ntt_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t                     state;
    logic                       mode;
    logic [2:0]                 s;
    logic [6:0]                 bf;
    logic [1:0]                 dcnt;
    logic                       last;
    logic                       go;
    logic                       nxt_mode;
    logic [2:0]                 nxt_s;
    logic [6:0]                 nxt_bf;
    logic [2:0]                 lg;
    logic [7:0]                 len;
    logic [7:0]                 mask;
    logic [7:0]                 g;
    logic [7:0]                 j;
    logic [7:0]                 tw;
    logic [8:0]                 inv_base;
    logic [PIPE_LAT-1:0][16:0]  dl;
    // Addresses are computed for the butterfly that will be presented next cycle,
    // so the read-side outputs can be registered and line up with rd_en_o.
    always_comb begin
        last     = dcnt == 2'(PIPE_LAT - 1);
        go       = state == IDLE  ? bus.start_i :
                   state == RUN   ? bf != 7'd127 :
                   state == DRAIN ? last && s != 3'd7 : 1'b0;
        nxt_mode = state == IDLE ? bus.mode_i : mode;
        nxt_s    = state == IDLE ? 3'd0 : state == DRAIN && s != 3'd7 ? s + 3'd1 : s;
        nxt_bf   = state == RUN ? bf + 7'd1 : 7'd0;
        lg       = nxt_mode ? 3'd7 - nxt_s : nxt_s;
        len      = 8'd1 << lg;
        mask     = len - 8'd1;
        g        = {1'b0, nxt_bf} >> lg;
        // j = 2*len*g + o: keep the low lg bits, shift the group bits up by one
        j        = (({1'b0, nxt_bf} & ~mask) << 1) | ({1'b0, nxt_bf} & mask);
        inv_base = 9'd256 >> nxt_s;
        tw       = nxt_mode ? (8'd1 << nxt_s) + g : 8'(inv_base - 9'd1 - {1'b0, g});
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            mode            <= 1'b0;
            s               <= 3'd0;
            bf              <= 7'd0;
            dcnt            <= 2'd0;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.ct_o        <= 1'b0;
            bus.rd_en_o     <= 1'b0;
            bus.rd_addr_a_o <= 8'd0;
            bus.rd_addr_b_o <= 8'd0;
            bus.tw_idx_o    <= 8'd0;
        end else begin
            bus.rd_en_o <= go;
            if (go) begin
                bus.rd_addr_a_o <= j;
                bus.rd_addr_b_o <= j + len;
                bus.tw_idx_o    <= tw;
            end
            case (state)
                IDLE: if (bus.start_i) begin
                    state      <= RUN;
                    mode       <= bus.mode_i;
                    bus.ct_o   <= bus.mode_i;
                    s          <= 3'd0;
                    bf         <= 7'd0;
                    bus.busy_o <= 1'b1;
                end
                RUN: if (bf == 7'd127) begin
                    state <= DRAIN;
                    dcnt  <= 2'd0;
                end else begin
                    bf <= bf + 7'd1;
                end
                DRAIN: if (!last) begin
                    dcnt <= dcnt + 2'd1;
                end else if (s == 3'd7) begin
                    state      <= DONE;
                    bus.done_o <= 1'b1;
                end else begin
                    state <= RUN;
                    s     <= s + 3'd1;
                    bf    <= 7'd0;
                end
                DONE: begin
                    state      <= IDLE;
                    bus.done_o <= 1'b0;
                    bus.busy_o <= 1'b0;
                end
            endcase
        end
    end
    // Write-back delay line: {valid, addr_a, addr_b} trails the read side by PIPE_LAT cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dl <= '0;
        end else begin
            dl[0] <= {bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o};
            for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
        end
    end
    assign bus.wr_en_o     = dl[PIPE_LAT-1][16];
    assign bus.wr_addr_a_o = dl[PIPE_LAT-1][15:8];
    assign bus.wr_addr_b_o = dl[PIPE_LAT-1][7:0];
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: directed bench for ntt_ctrl with PIPE_LAT = 1 and PIPE_LAT = 3 instances.
module tb_ntt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    ntt_ctrl_if b1 ();
    ntt_ctrl_if b3 ();
    ntt_ctrl #(.PIPE_LAT(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));
    ntt_ctrl #(.PIPE_LAT(3)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3.slave));
    logic       p_rd, p_wr, p_done, p_busy, p_ct;
    logic [7:0] p_a, p_b, p_tw, p_wa, p_wb;
    always_comb begin
        p_rd   = sel ? b3.rd_en_o     : b1.rd_en_o;
        p_wr   = sel ? b3.wr_en_o     : b1.wr_en_o;
        p_done = sel ? b3.done_o      : b1.done_o;
        p_busy = sel ? b3.busy_o      : b1.busy_o;
        p_ct   = sel ? b3.ct_o        : b1.ct_o;
        p_a    = sel ? b3.rd_addr_a_o : b1.rd_addr_a_o;
        p_b    = sel ? b3.rd_addr_b_o : b1.rd_addr_b_o;
        p_tw   = sel ? b3.tw_idx_o    : b1.tw_idx_o;
        p_wa   = sel ? b3.wr_addr_a_o : b1.wr_addr_a_o;
        p_wb   = sel ? b3.wr_addr_b_o : b1.wr_addr_b_o;
    end
    logic       c_rd [0:1099];
    logic       c_wr [0:1099];
    logic       c_done [0:1099];
    logic       c_busy [0:1099];
    logic       c_ct [0:1099];
    logic [7:0] c_a [0:1099];
    logic [7:0] c_b [0:1099];
    logic [7:0] c_tw [0:1099];
    logic [7:0] c_wa [0:1099];
    logic [7:0] c_wb [0:1099];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic void model(input bit m, input int s, input int bf,
                                  output logic [7:0] a, output logic [7:0] b, output logic [7:0] t);
        int len = m ? (128 >> s) : (1 << s);
        int g   = bf / len;
        int ja  = 2 * len * g + bf % len;
        a = 8'(ja);
        b = 8'(ja + len);
        t = 8'(m ? (1 << s) + g : (256 >> s) - 1 - g);
    endfunction
    task automatic set_start(input bit v, input bit m);
        if (sel) begin
            b3.start_i = v;
            b3.mode_i  = m;
        end else begin
            b1.start_i = v;
            b1.mode_i  = m;
        end
    endtask
    task automatic launch(input bit m);
        @(negedge clk);
        set_start(1'b1, m);
        @(posedge clk);
        #1 set_start(1'b0, 1'b0);
    endtask
    task automatic capture(input int n, input int pulse_at);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            c_rd[k] = p_rd;   c_wr[k] = p_wr;   c_done[k] = p_done;
            c_busy[k] = p_busy; c_ct[k] = p_ct;
            c_a[k] = p_a;     c_b[k] = p_b;     c_tw[k] = p_tw;
            c_wa[k] = p_wa;   c_wb[k] = p_wb;
            if (pulse_at > 0 && k >= pulse_at && k < pulse_at + 5) set_start(1'b1, k[0]);
            else set_start(1'b0, 1'b0);
        end
    endtask
    task automatic analyze(input string nm, input int p, input bit m, input int n);
        int tot = 8 * (128 + p);
        int e_rd = 0, e_wr = 0, e_dn = 0, e_ct = 0, e_sb = 0, e_raw = 0, n_drn = 0;
        int hits [8][256];
        int last_wr [8];
        int first_rd [8];
        logic [7:0] ea, eb, et;
        for (int s = 0; s < 8; s++) begin
            last_wr[s] = 0;
            first_rd[s] = 0;
            for (int a = 0; a < 256; a++) hits[s][a] = 0;
        end
        for (int k = 1; k <= n; k++) begin
            int  s  = (k - 1) / (128 + p);
            int  r  = (k - 1) % (128 + p);
            int  kk = k - p;
            bit  er = k <= tot && r < 128;
            bit  ew = kk >= 1 && kk <= tot && ((kk - 1) % (128 + p)) < 128;
            if (c_rd[k] !== er) e_rd++;
            if (er) begin
                model(m, s, r, ea, eb, et);
                if (c_a[k] !== ea || c_b[k] !== eb || c_tw[k] !== et) e_rd++;
            end
            if (k <= tot && c_rd[k] === 1'b0) n_drn++;
            if (k <= tot && c_rd[k] === 1'b1 && first_rd[s] == 0) first_rd[s] = k;
            if (c_wr[k] !== ew) e_wr++;
            if (ew) begin
                model(m, (kk - 1) / (128 + p), (kk - 1) % (128 + p), ea, eb, et);
                if (c_wa[k] !== ea || c_wb[k] !== eb) e_wr++;
            end
            if (c_wr[k] === 1'b1 && kk >= 1 && kk <= tot) begin
                int sw = (kk - 1) / (128 + p);
                hits[sw][c_wa[k]]++;
                hits[sw][c_wb[k]]++;
                last_wr[sw] = k;
            end
            if (c_done[k] !== (k == tot + 1) || c_busy[k] !== (k <= tot + 1)) e_dn++;
            if (c_ct[k] !== m) e_ct++;
        end
        for (int s = 0; s < 8; s++)
            for (int a = 0; a < 256; a++)
                if (hits[s][a] != 1) e_sb++;
        for (int s = 0; s < 7; s++)
            if (first_rd[s+1] == 0 || last_wr[s] >= first_rd[s+1]) e_raw++;
        chk({nm, "_rd_seq"}, e_rd, 0);
        chk({nm, "_wr_seq"}, e_wr, 0);
        chk({nm, "_drain_cycles"}, n_drn, 8 * p);
        chk({nm, "_done_busy"}, e_dn, 0);
        chk({nm, "_ct_hold"}, e_ct, 0);
        chk({nm, "_write_once"}, e_sb, 0);
        chk({nm, "_raw_order"}, e_raw, 0);
        chk({nm, "_last_wr_in_drain"}, last_wr[7], tot);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int nwr;
        b1.start_i = 1'b0; b1.mode_i = 1'b0;
        b3.start_i = 1'b0; b3.mode_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_u1_ctl", {b1.busy_o, b1.done_o, b1.ct_o, b1.rd_en_o, b1.wr_en_o}, 0);
        chk("rst_u1_addr", b1.rd_addr_a_o | b1.rd_addr_b_o | b1.tw_idx_o | b1.wr_addr_a_o | b1.wr_addr_b_o, 0);
        chk("rst_u3_ctl", {b3.busy_o, b3.done_o, b3.ct_o, b3.rd_en_o, b3.wr_en_o}, 0);
        rst = 1'b0;
        // forward, PIPE_LAT=1, with start/mode pulsed mid-operation
        sel = 1'b0;
        launch(1'b1);
        capture(1060, 500);
        analyze("fwd_p1", 1, 1'b1, 1060);
        chk("fwd_c1_rd", {c_rd[1], c_ct[1], c_busy[1]}, 3'b111);
        chk("fwd_c1_a", c_a[1], 0);
        chk("fwd_c1_b", c_b[1], 128);
        chk("fwd_c1_tw", c_tw[1], 1);
        chk("fwd_c128_ab", {c_a[128], c_b[128], c_tw[128]}, {8'd127, 8'd255, 8'd1});
        chk("fwd_c129_rd", c_rd[129], 0);
        chk("fwd_c129_wr", {c_wr[129], c_wa[129], c_wb[129]}, {1'b1, 8'd127, 8'd255});
        chk("fwd_c130", {c_a[130], c_b[130], c_tw[130]}, {8'd0, 8'd64, 8'd2});
        chk("fwd_s7_bf0", {c_a[904], c_b[904], c_tw[904]}, {8'd0, 8'd1, 8'd128});
        chk("fwd_s7_bf127", {c_a[1031], c_b[1031], c_tw[1031]}, {8'd254, 8'd255, 8'd255});
        chk("fwd_done", {c_done[1032], c_done[1033], c_done[1034]}, 3'b010);
        chk("fwd_busy", {c_busy[1033], c_busy[1034]}, 2'b10);
        // inverse, PIPE_LAT=3
        sel = 1'b1;
        launch(1'b0);
        capture(1060, 0);
        analyze("inv_p3", 3, 1'b0, 1060);
        chk("inv_c1_ct", c_ct[1], 0);
        chk("inv_s0_bf0", {c_a[1], c_b[1], c_tw[1]}, {8'd0, 8'd1, 8'd255});
        chk("inv_s0_bf127", {c_a[128], c_b[128], c_tw[128]}, {8'd254, 8'd255, 8'd128});
        chk("inv_drain", {c_rd[129], c_rd[130], c_rd[131], c_rd[132]}, 4'b0001);
        chk("inv_c131_wr", {c_wr[131], c_wa[131], c_wb[131]}, {1'b1, 8'd254, 8'd255});
        chk("inv_s1_bf0", {c_a[132], c_b[132], c_tw[132]}, {8'd0, 8'd2, 8'd127});
        chk("inv_s7_bf5", {c_a[923], c_b[923], c_tw[923]}, {8'd5, 8'd133, 8'd1});
        chk("inv_done", {c_done[1048], c_done[1049], c_done[1050]}, 3'b010);
        // reset mid-operation at stage 3 bf 40
        sel = 1'b0;
        launch(1'b1);
        capture(428, 0);
        chk("mid_s3_bf40", {c_a[428], c_b[428], c_tw[428]}, {8'd72, 8'd88, 8'd10});
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", {b1.busy_o, b1.done_o, b1.ct_o, b1.rd_en_o, b1.wr_en_o}, 0);
        chk("mid_rst_addr", b1.rd_addr_a_o | b1.rd_addr_b_o | b1.tw_idx_o | b1.wr_addr_a_o | b1.wr_addr_b_o, 0);
        rst = 1'b0;
        nwr = 0;
        repeat (300) begin
            @(negedge clk);
            if (b1.wr_en_o !== 1'b0 || b1.busy_o !== 1'b0) nwr++;
        end
        chk("mid_no_wr_after_rst", nwr, 0);
        launch(1'b1);
        capture(1060, 0);
        analyze("fwd_p1_again", 1, 1'b1, 1060);
        chk("again_c1", {c_a[1], c_b[1], c_tw[1]}, {8'd0, 8'd128, 8'd1});
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
- Sequencer that drives the butterfly unit through a full 256-point Dilithium NTT (forward, CT) or inverse NTT (GS), q = 8380417, 24-bit coefficients.
- Sits directly upstream of the butterfly unit. Generates coefficient-RAM read addresses, twiddle index and CT/GS select.
- Delays the addresses through a pipeline so butterfly results are written back in place.
- Final n^-1 scaling of the inverse transform and twiddle sign handling are outside this block.

Parameters:
- PIPE_LAT, 1, cycles from rd_en_o to valid butterfly outputs at the RAM write port (RAM read latency plus butterfly latency); legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start request; sampled only in IDLE
- mode_i  in  1  1 = forward NTT (CT), 0 = inverse NTT (GS); sampled with start_i
- busy_o  out  1  high from the cycle after start is accepted until DONE inclusive
- done_o  out  1  one-cycle pulse after the final write
- ct_o  out  1  butterfly CT select, held for the whole operation
- rd_en_o  out  1  read strobe for both RAM ports
- rd_addr_a_o  out  8  even-coefficient read address
- rd_addr_b_o  out  8  odd-coefficient read address
- tw_idx_o  out  8  twiddle ROM index, aligned with rd_en_o
- wr_en_o  out  1  write strobe for both RAM ports
- wr_addr_a_o  out  8  even_o write address
- wr_addr_b_o  out  8  odd_o write address

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset state: all outputs 0, state IDLE, counters 0, delay line cleared. Reset mid-operation aborts immediately; no further writes are issued.
- States:
  - IDLE -> RUN on start_i; latch mode_i, set ct_o = mode_i, stage s = 0, butterfly counter bf = 0.
  - RUN: one butterfly per cycle, rd_en_o = 1, bf 0..127. At bf = 127 go to DRAIN.
  - DRAIN: PIPE_LAT cycles with rd_en_o = 0, so stage s writes land before stage s+1 reads (RAW hazard). Then, if s < 7: s++, bf = 0, go to RUN; else go to DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- start_i outside IDLE is ignored; mode_i is ignored except when start is accepted.
- Address generation:
  - Forward: len = 128 >> s. Inverse: len = 1 << s.
  - g = bf / len, o = bf % len, j = 2*len*g + o. Use shift/mask only.
  - rd_addr_a_o = j, rd_addr_b_o = j + len.
- Twiddle index:
  - Forward: tw_idx_o = (1 << s) + g.
  - Inverse: tw_idx_o = (256 >> s) - 1 - g.
- Output registering: read-side outputs are registered and valid in the cycle rd_en_o = 1.
- Write side: a PIPE_LAT-deep shift register carries {valid, addr_a, addr_b}.
  - wr_en_o and wr_addr_*_o equal the read-side values exactly PIPE_LAT cycles earlier.
  - The last write of stage 7 occurs in the last DRAIN cycle.
- Timing, with start accepted at edge E0 (cycle 0):
  - stage s RUN occupies cycles 1 + s*(128+PIPE_LAT) .. +127;
  - done_o is high in cycle 8*(128+PIPE_LAT) + 1;
  - busy_o is high in cycles 1 .. that cycle.
- Counters: no wrap-around beyond the defined ranges. s saturates at 7; bf is reset at each stage entry.

Test Plan:
- Reset, then forward start (PIPE_LAT=1) -> cycle 1: rd 0/128, tw 1, ct_o=1. Cycle 128: rd 127/255, tw 1. Cycle 129: rd_en_o=0, wr 127/255. Cycle 130: stage 1 rd 0/64, tw 2.
- Forward stage 7 -> bf 0: rd 0/1, tw 128. bf 127: rd 254/255, tw 255. done_o high only in cycle 1033, busy_o low in cycle 1034.
- Inverse (mode_i=0) -> ct_o=0. Stage 0 bf 0: rd 0/1, tw 255. Stage 0 bf 127: rd 254/255, tw 128. Stage 7 bf 5: rd 5/133, tw 1.
- PIPE_LAT=3 -> every wr_* equals rd_* from 3 cycles earlier; 3 DRAIN cycles per stage; done_o in cycle 1049. Scoreboard: each address 0..255 is written exactly once per stage, and no read of stage s+1 occurs before the last write of stage s.
- start_i pulsed while busy, with mode_i toggled -> sequence and ct_o unchanged; done_o still fires exactly once.
- rst_i asserted at stage 3 bf 40 -> next cycle all outputs 0, no wr_en_o afterwards. A new start behaves like the first scenario.
